// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings, FSM state type and arithmetic helpers for the
// HI/LO multiply/divide unit.
package mdu_pkg;

  // multiply / divide control codes from the main decoder
  localparam logic [1:0] MD_SIGNED   = 2'b11;
  localparam logic [1:0] MD_UNSIGNED = 2'b10;

  // HI_sel / LO_sel source select
  localparam logic [1:0] SEL_RS   = 2'b00;
  localparam logic [1:0] SEL_MUL  = 2'b01;
  localparam logic [1:0] SEL_DIV  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  // MultoRF read-back codes
  localparam logic [1:0] RF_HI = 2'd2;
  localparam logic [1:0] RF_LO = 2'd3;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // Magnitude of x when treated as signed; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  // Full 64-bit product; sign-extending both operands to 64 bits makes the
  // truncated 64x64 product correct for both signed and unsigned inputs.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{sgn & a[31]}}, a};
    bx = {{32{sgn & b[31]}}, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative unsigned 32-bit radix-2 restoring divider.
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b; the first quotient bit is resolved on this edge
//   a, b       : dividend, divisor (unsigned magnitudes)
//   quo, rem   : quotient and remainder, valid from the cycle done is high
//   done       : one-cycle pulse, DIV_ITERS-1 cycles after the start cycle
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        done
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [31:0]   rem_q;
  logic [31:0]   quo_q;
  logic [31:0]   div_q;
  logic [CW-1:0] cnt_q;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor, keep the difference if no borrow.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] sh;
    logic [32:0] diff;
    sh   = {r, q[31]};
    diff = sh - {1'b0, d};
    if (!diff[32]) return {diff[31:0], q[30:0], 1'b1};
    else           return {sh[31:0], q[30:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem_q, quo_q} <= div_step(32'd0, a, b);
        div_q          <= b;
        cnt_q          <= CW'(DIV_ITERS - 1);
      end else if (cnt_q != '0) begin
        {rem_q, quo_q} <= div_step(rem_q, quo_q, div_q);
        cnt_q          <= cnt_q - 1'b1;
        done           <= (cnt_q == CW'(1));
      end
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk, rst_n        : clock, async active-low reset
//   valid, kill       : live execute-stage instruction, flush
//   multiply, divide  : mult/div request codes (1x request, x1 signed)
//   HI_sel, LO_sel    : HI/LO source (rs, mul, div, hold)
//   MultoRF           : mfhi/mflo read-back, only used for stall decode
//   rs_data, rt_data  : operands
//   hi, lo            : HI/LO registers
//   busy, stall, done : op in flight, hazard stall request, result-written pulse
//
// state | meaning
// IDLE  | no op in flight; accepts mult/div/mthi/mtlo
// MUL   | product latency down-count
// DIV   | divider iterating on operand magnitudes
// FIX   | apply signs / divide-by-zero result, write HI/LO
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int XLEN    = 32  // fixed at 32 for this ISA
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic            kill,
  input  logic [1:0]      multiply,
  input  logic [1:0]      divide,
  input  logic [1:0]      HI_sel,
  input  logic [1:0]      LO_sel,
  input  logic [1:0]      MultoRF,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  // MUL is entered with MUL_LAT-2 so the write lands MUL_LAT edges after
  // accept; MUL_LAT=1 writes on the accept edge and never enters MUL.
  localparam logic [1:0] MUL_CNT_INIT = (MUL_LAT > 1) ? 2'(MUL_LAT - 2) : 2'd0;

  mdu_state_e  state_q, state_d;
  logic [31:0] op_a, op_b;
  logic        op_signed;
  logic [1:0]  cnt_q;

  logic        accept, req_mul, req_div, mul_sgn, div_sgn;
  logic [63:0] prod_live, prod_held;
  logic [31:0] div_quo, div_rem;
  logic        div_done;
  logic [31:0] quo_fix, rem_fix;

  assign accept  = valid & ~busy & ~kill;
  assign req_mul = (multiply == MD_SIGNED || multiply == MD_UNSIGNED) &&
                   (HI_sel == SEL_MUL) && (LO_sel == SEL_MUL);
  assign mul_sgn = (multiply == MD_SIGNED);
  assign req_div = (divide == MD_SIGNED || divide == MD_UNSIGNED) &&
                   (HI_sel == SEL_DIV) && (LO_sel == SEL_DIV);
  assign div_sgn = (divide == MD_SIGNED);

  assign prod_live = mul64(rs_data, rt_data, mul_sgn);
  assign prod_held = mul64(op_a, op_b, op_signed);

  mdu_divider u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & req_div),
    .a     (mag(rs_data, div_sgn)),
    .b     (mag(rt_data, div_sgn)),
    .quo   (div_quo),
    .rem   (div_rem),
    .done  (div_done)
  );

  // Quotient is negative iff operand signs differ, remainder follows the
  // dividend. Divide-by-zero overrides with all-ones / raw dividend.
  always_comb begin
    quo_fix = (op_signed && (op_a[31] ^ op_b[31])) ? (~div_quo + 32'd1) : div_quo;
    rem_fix = (op_signed && op_a[31]) ? (~div_rem + 32'd1) : div_rem;
    if (op_b == 32'd0) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = op_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && req_mul && (MUL_LAT > 1)) state_d = ST_MUL;
        else if (accept && req_div)             state_d = ST_DIV;
      end
      ST_MUL:  if (kill || cnt_q == 2'd0) state_d = ST_IDLE;
      ST_DIV: begin
        if (kill)          state_d = ST_IDLE;
        else if (div_done) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    stall = valid & busy &
            (multiply[1] | divide[1] | (HI_sel == SEL_RS) | (LO_sel == SEL_RS) |
             (MultoRF == RF_HI) | (MultoRF == RF_LO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      cnt_q     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (req_mul) begin
              op_a      <= rs_data;
              op_b      <= rt_data;
              op_signed <= mul_sgn;
              cnt_q     <= MUL_CNT_INIT;
              if (MUL_LAT == 1) begin
                {hi, lo} <= prod_live;
                done     <= 1'b1;
              end
            end else if (req_div) begin
              op_a      <= rs_data;
              op_b      <= rt_data;
              op_signed <= div_sgn;
            end else begin
              if (HI_sel == SEL_RS) hi <= rs_data;
              if (LO_sel == SEL_RS) lo <= rs_data;
            end
          end
        end
        ST_MUL: begin
          if (!kill) begin
            if (cnt_q == 2'd0) begin
              {hi, lo} <= prod_held;
              done     <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
        end
        ST_FIX: begin
          if (!kill) begin
            hi   <= rem_fix;
            lo   <= quo_fix;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;

  logic        clk, rst_n, valid, kill;
  logic [1:0]  multiply, divide, HI_sel, LO_sel, MultoRF;
  logic [31:0] rs_data, rt_data, hi, lo;
  logic        busy, stall, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  mdu_hilo #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .kill(kill),
    .multiply(multiply), .divide(divide), .HI_sel(HI_sel), .LO_sel(LO_sel),
    .MultoRF(MultoRF), .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cyc=%0d hi=%h lo=%h", cyc, hi, lo);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (hi !== mon_e.hi || lo !== mon_e.lo) begin
          failures++;
          $display("FAIL hilo cyc=%0d got hi=%h lo=%h expected hi=%h lo=%h",
                   cyc, hi, lo, mon_e.hi, mon_e.lo);
        end
        checks++;
        if (cyc != mon_e.due) begin
          failures++;
          $display("FAIL latency got cycle %0d expected cycle %0d", cyc, mon_e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_idle();
    valid    = 1'b0;
    kill     = 1'b0;
    multiply = 2'b00;
    divide   = 2'b00;
    HI_sel   = SEL_HOLD;
    LO_sel   = SEL_HOLD;
    MultoRF  = 2'd0;
    rs_data  = '0;
    rt_data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] mul, input logic [1:0] dv, input logic [1:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
    valid    = 1'b1;
    multiply = mul;
    divide   = dv;
    HI_sel   = sel;
    LO_sel   = sel;
    rs_data  = a;
    rt_data  = b;
  endtask

  task automatic wait_drain(input string name, input int exp_busy);
    int bc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) bc++;
      step();
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got %0d pending expected 0 pending", name, sb.size());
      sb.delete();
    end
    check({name, "_busy_len"}, 32'(bc), 32'(exp_busy));
  endtask

  task automatic run_op(input string name, input logic [1:0] mul, input logic [1:0] dv,
                        input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    sb.push_back('{hi: ehi, lo: elo, due: cyc + lat});
    drive_op(mul, dv, sel, a, b);
    step();
    set_idle();
    wait_drain(name, lat - 1);
  endtask

  initial begin
    int sc;
    set_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    step();

    run_op("mult_neg", MD_SIGNED, 2'b00, SEL_MUL, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    run_op("multu_max", MD_UNSIGNED, 2'b00, SEL_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("mult_min2", MD_SIGNED, 2'b00, SEL_MUL, 32'h8000_0000, 32'd2,
           32'hFFFF_FFFF, 32'h0, MUL_LAT);
    run_op("multu_min2", MD_UNSIGNED, 2'b00, SEL_MUL, 32'h8000_0000, 32'd2,
           32'h1, 32'h0, MUL_LAT);

    run_op("div_m7_2", 2'b00, MD_SIGNED, SEL_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div_7_m2", 2'b00, MD_SIGNED, SEL_DIV, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divu_100_7", 2'b00, MD_UNSIGNED, SEL_DIV, 32'd100, 32'd7,
           32'd2, 32'd14, DIV_LAT);
    run_op("div_by0", 2'b00, MD_SIGNED, SEL_DIV, 32'h1234_5678, 32'd0,
           32'h1234_5678, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_neg_by0", 2'b00, MD_SIGNED, SEL_DIV, 32'h8000_0001, 32'd0,
           32'h8000_0001, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_ovf", 2'b00, MD_SIGNED, SEL_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, DIV_LAT);

    // mthi / mtlo while idle
    valid = 1'b1; HI_sel = SEL_RS; rs_data = 32'h0000_ABCD;
    @(negedge clk);
    check("mthi_stall", 32'(stall), 32'h0);
    step();
    set_idle();
    check("mthi_hi", hi, 32'h0000_ABCD);
    check("mthi_lo", lo, 32'h8000_0000);
    valid = 1'b1; LO_sel = SEL_RS; rs_data = 32'h0000_1234;
    step();
    set_idle();
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi", hi, 32'h0000_ABCD);

    // mflo presented at N+5 of a divide stalls until the result is visible
    sb.push_back('{hi: 32'd2, lo: 32'd14, due: cyc + DIV_LAT});
    drive_op(2'b00, MD_UNSIGNED, SEL_DIV, 32'd100, 32'd7);
    step();
    set_idle();
    repeat (4) step();
    valid = 1'b1; MultoRF = RF_LO;
    sc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      step();
    end
    check("mflo_stall_len", 32'(sc), 32'd29);
    check("mflo_lo", lo, 32'd14);
    step();
    set_idle();
    wait_drain("mflo", 0);

    // kill at N+10 of a divide
    valid = 1'b1; HI_sel = SEL_RS; rs_data = 32'h11;
    step();
    set_idle();
    valid = 1'b1; LO_sel = SEL_RS; rs_data = 32'h11;
    step();
    set_idle();
    drive_op(2'b00, MD_UNSIGNED, SEL_DIV, 32'h1000, 32'd3);
    step();
    set_idle();
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    @(negedge clk);
    check("kill_busy", 32'(busy), 32'h0);
    check("kill_done", 32'(done), 32'h0);
    repeat (40) step();
    check("kill_hi", hi, 32'h11);
    check("kill_lo", lo, 32'h11);

    // kill together with a mult request in IDLE accepts nothing
    drive_op(MD_SIGNED, 2'b00, SEL_MUL, 32'd3, 32'd5);
    kill = 1'b1;
    step();
    set_idle();
    @(negedge clk);
    check("kill_idle_busy", 32'(busy), 32'h0);
    repeat (5) step();
    check("kill_idle_lo", lo, 32'h11);

    // reset in the middle of a mult
    drive_op(MD_SIGNED, 2'b00, SEL_MUL, 32'd3, 32'd5);
    step();
    set_idle();
    check("mid_mult_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    #2;
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_lo", lo, 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
